timer_counter: RTL and testbench

Parametrised, multi-mode counter/timer that generalises the existing single-purpose counter. It adds a programmable prescaler, up/down direction, a programmable terminal limit, wrap/saturate/one-shot modes, synchronous load/clear and a terminal-count pulse. It sits on the processor's peripheral side as a cycle/interval timer. Its count value is visible to the core as a register-readable output.

---
 rtl/ctr_pkg.sv | 14 +
 rtl/timer_counter_if.sv | 28 ++
 rtl/ctr_prescaler.sv | 28 ++
 rtl/timer_counter.sv | 118 +++++++++++
 tb/tb_timer_counter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/ctr_pkg.sv
// Shared definitions for the multi-mode timer/counter: mode codes and FSM state encoding.
package ctr_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/timer_counter_if.sv
// Control/status bundle between the core's peripheral side and the timer_counter block.
interface timer_counter_if #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
);
    logic                  en;
    logic                  clr;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic                  dir;
    logic [1:0]            mode;
    logic [WIDTH-1:0]      limit;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      out;
    logic                  tc;
    logic                  done;
    logic                  busy;

    modport master (
        output en, clr, load, load_val, dir, mode, limit, prescale,
        input  out, tc, done, busy
    );

    modport slave (
        input  en, clr, load, load_val, dir, mode, limit, prescale,
        output out, tc, done, busy
    );
endinterface

// File: rtl/ctr_prescaler.sv
// Programmable divider: emits one tick every prescale+1 running cycles, frozen while not running.
module ctr_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  restart,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);
    localparam logic [PRESCALE_W-1:0] ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] pre_cnt;

    // >= so that shrinking prescale below the current count still fires on the next compare
    assign tick = run && (pre_cnt >= prescale);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
        end else if (restart) begin
            pre_cnt <= '0;
        end else if (run) begin
            pre_cnt <= tick ? '0 : pre_cnt + ONE;
        end
    end
endmodule

// File: rtl/timer_counter.sv
// Multi-mode up/down timer/counter with prescaler, wrap/saturate/one-shot modes and terminal-count pulse.
module timer_counter
    import ctr_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    timer_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] cnt;
    logic             tc_q;
    logic             sat;
    logic             tick;
    logic             run;
    logic             restart;
    logic             at_bound;
    logic             oneshot_hit;

    // Counting happens whenever enabled and not finished, so pausing en costs exactly the paused cycles
    assign run         = bus.en && (state != ST_DONE);
    assign restart     = bus.clr || bus.load;
    assign at_bound    = bus.dir ? (cnt >= bus.limit) : (cnt == '0);
    assign oneshot_hit = tick && at_bound && (bus.mode == MODE_ONESHOT);

    ctr_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .restart  (restart),
        .prescale (bus.prescale),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (bus.clr) begin
            next_state = ST_IDLE;
        end else if (bus.load) begin
            next_state = bus.en ? ST_RUN : ST_IDLE;
        end else if (oneshot_hit) begin
            next_state = ST_DONE;
        end else if (state != ST_DONE) begin
            next_state = bus.en ? ST_RUN : ST_IDLE;
        end
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            ST_RUN:  bus.busy = 1'b1;
            ST_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

    // sat remembers that the saturate boundary already produced its tc pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            tc_q <= 1'b0;
            sat  <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (bus.clr) begin
                cnt <= '0;
                sat <= 1'b0;
            end else if (bus.load) begin
                cnt <= bus.load_val;
                sat <= 1'b0;
            end else begin
                if (tick) begin
                    if (at_bound) begin
                        case (bus.mode)
                            MODE_SAT: begin
                                if (!sat) begin
                                    tc_q <= 1'b1;
                                end
                                sat <= 1'b1;
                            end
                            MODE_ONESHOT: begin
                                tc_q <= 1'b1;
                            end
                            default: begin
                                cnt  <= bus.dir ? '0 : bus.limit;
                                tc_q <= 1'b1;
                            end
                        endcase
                    end else begin
                        cnt <= bus.dir ? cnt + ONE : cnt - ONE;
                    end
                end
                if (!at_bound) begin
                    sat <= 1'b0;
                end
            end
        end
    end

    assign bus.out = cnt;
    assign bus.tc  = tc_q;
endmodule

// File: tb/tb_timer_counter.sv
// Directed scoreboard bench for timer_counter: stimulus pushes expected outputs, a monitor pops and compares.
module tb_timer_counter;

    typedef struct packed {
        logic [15:0] id;
        logic [7:0]  out;
        logic        tc;
        logic        done;
        logic        busy;
    } exp_t;

    logic clk;
    logic reset;
    exp_t exp_q[$];
    int   total;
    int   bad;
    int   step;

    timer_counter_if #(.WIDTH(8), .PRESCALE_W(4)) bus ();

    timer_counter #(
        .WIDTH      (8),
        .PRESCALE_W (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compareField(input string name, input int id, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL step%0d %s: got %0d expected %0d", id, name, got, want);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue what must appear after the next rising edge
    task automatic applyStimulus(input logic e, input logic c, input logic l, input logic [7:0] lv,
                                 input logic [7:0] eo, input logic et, input logic ed, input logic eb);
        exp_t x;
        @(negedge clk);
        bus.en       = e;
        bus.clr      = c;
        bus.load     = l;
        bus.load_val = lv;
        step++;
        x.id   = step[15:0];
        x.out  = eo;
        x.tc   = et;
        x.done = ed;
        x.busy = eb;
        exp_q.push_back(x);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] eo, input logic et,
                               input logic ed, input logic eb);
        total++;
        if (bus.out !== eo || bus.tc !== et || bus.done !== ed || bus.busy !== eb) begin
            bad++;
            $display("[TB] FAIL %s: got out=%0d tc=%b done=%b busy=%b expected out=%0d tc=%b done=%b busy=%b",
                     name, bus.out, bus.tc, bus.done, bus.busy, eo, et, ed, eb);
        end
    endtask

    // Config is only changed after an idle clear cycle so it never lands on a checked edge
    task automatic setConfig(input logic d, input logic [1:0] m, input logic [7:0] lim, input logic [3:0] p);
        @(negedge clk);
        bus.en       = 1'b0;
        bus.clr      = 1'b1;
        bus.load     = 1'b0;
        bus.dir      = d;
        bus.mode     = m;
        bus.limit    = lim;
        bus.prescale = p;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                compareField("out",  int'(e.id), int'(bus.out),  int'(e.out));
                compareField("tc",   int'(e.id), int'(bus.tc),   int'(e.tc));
                compareField("done", int'(e.id), int'(bus.done), int'(e.done));
                compareField("busy", int'(e.id), int'(bus.busy), int'(e.busy));
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        step  = 0;
        reset = 1'b0;
        bus.en = 1'b0; bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = '0;
        bus.dir = 1'b1; bus.mode = 2'b00; bus.limit = 8'd3; bus.prescale = 4'd0;
        #12;
        checkOutput("reset_state", 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] up wrap, limit=3");
        applyStimulus(1, 0, 0, 0, 8'd1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd2, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd3, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd0, 1, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd2, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd3, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd0, 1, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 8'd1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 8'd0, 0, 0, 0);

        $display("[TB] async reset mid-count");
        setConfig(1, 2'b00, 8'd255, 4'd0);
        for (int i = 1; i <= 5; i++) applyStimulus(1, 0, 0, 0, 8'(i), 0, 0, 1);
        @(posedge clk);
        #2;
        bus.en = 1'b0;
        reset  = 1'b0;
        #1;
        checkOutput("async_reset", 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1, 0, 0, 0, 8'd1, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 8'd0, 0, 0, 0);

        $display("[TB] prescale=2 with en pause");
        setConfig(1, 2'b00, 8'd255, 4'd2);
        applyStimulus(1, 0, 0, 0, 8'd0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 8'd1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 8'd1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 8'd1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd2, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd2, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd2, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd3, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 8'd0, 0, 0, 0);

        $display("[TB] down one-shot");
        setConfig(0, 2'b10, 8'd7, 4'd0);
        applyStimulus(0, 0, 1, 8'd4, 8'd4, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 8'd3, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd2, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd0, 1, 1, 0);
        applyStimulus(1, 0, 0, 0, 8'd0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 8'd0, 0, 1, 0);
        applyStimulus(1, 0, 1, 8'd2, 8'd2, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd0, 1, 1, 0);
        applyStimulus(0, 1, 0, 0, 8'd0, 0, 0, 0);

        $display("[TB] saturate up, limit=2");
        setConfig(1, 2'b01, 8'd2, 4'd0);
        applyStimulus(1, 0, 0, 0, 8'd1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd2, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd2, 1, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd2, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd2, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 8'd0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 8'd1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd2, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd2, 1, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd2, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 8'd0, 0, 0, 0);

        $display("[TB] down wrap, limit=3");
        setConfig(0, 2'b00, 8'd3, 4'd0);
        applyStimulus(0, 0, 1, 8'd1, 8'd1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 8'd0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd3, 1, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd2, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd3, 1, 0, 1);
        applyStimulus(0, 1, 0, 0, 8'd0, 0, 0, 0);

        $display("[TB] up wrap, limit=0");
        setConfig(1, 2'b00, 8'd0, 4'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 8'd0, 1, 0, 1);
        applyStimulus(0, 1, 0, 0, 8'd0, 0, 0, 0);

        $display("[TB] reserved mode acts as wrap");
        setConfig(1, 2'b11, 8'd1, 4'd0);
        applyStimulus(1, 0, 0, 0, 8'd1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd0, 1, 0, 1);
        applyStimulus(0, 1, 0, 0, 8'd0, 0, 0, 0);

        $display("[TB] clr/load/tick priority");
        setConfig(1, 2'b00, 8'd255, 4'd0);
        applyStimulus(1, 0, 0, 0, 8'd1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd2, 0, 0, 1);
        applyStimulus(1, 1, 1, 8'd9, 8'd0, 0, 0, 0);
        applyStimulus(1, 0, 1, 8'd9, 8'd9, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 8'd10, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 8'd0, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
